// File: rtl/tdc7200_pkg.sv
// TDC7200 register map, SPI command-byte layout and the SPI master state encoding.
package tdc7200_pkg;

  localparam logic [5:0] ADDR_CONFIG1      = 6'h00;
  localparam logic [5:0] ADDR_CONFIG2      = 6'h01;
  localparam logic [5:0] ADDR_INT_STATUS   = 6'h02;
  localparam logic [5:0] ADDR_TIME1        = 6'h10;
  localparam logic [5:0] ADDR_CLOCK_COUNT1 = 6'h11;
  localparam logic [5:0] ADDR_CALIBRATION1 = 6'h1B;
  localparam logic [5:0] ADDR_CALIBRATION2 = 6'h1C;

  localparam int CMD_AUTOINC_BIT = 7;
  localparam int CMD_RW_BIT      = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_CS_GAP
  } spi_state_e;

  function automatic logic [7:0] make_cmd(input logic autoinc, input logic write,
                                          input logic [5:0] addr);
    logic [7:0] c;
    c = {2'b00, addr};
    c[CMD_AUTOINC_BIT] = autoinc;
    c[CMD_RW_BIT]      = write;
    return c;
  endfunction

endpackage

// File: rtl/tdc_sclk_div.sv
// SCLK half-period divider: strobes rise/fall every CLK_DIV cycles while enabled;
// counter and phase are forced back to zero whenever the enable is low.
module tdc_sclk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic rise_o,
  output logic fall_o,
  output logic sclk_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          term;

  assign term   = en_i && (cnt_q == LAST);
  assign rise_o = term && !phase_q;
  assign fall_o = term && phase_q;
  assign sclk_o = phase_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (term) begin
      cnt_d   = '0;
      phase_d = !phase_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/tdc_spi_master.sv
// Mode-0 SPI master for TDC7200 register access (command byte + 1 or 3 data bytes),
// plus a synchronised falling-edge detector on the TDC interrupt line.
module tdc_spi_master
  import tdc7200_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 2
) (
  input  logic        tdc_clk,
  input  logic        tdc_rstb,
  input  logic        start,
  input  logic [5:0]  cmd_addr,
  input  logic        cmd_write,
  input  logic        cmd_autoinc,
  input  logic        cmd_long,
  input  logic [23:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [23:0] rd_data,
  output logic        tdc_sclk,
  output logic        tdc_csb,
  output logic        tdc_din,
  input  logic        tdc_dout,
  input  logic        tdc_intb,
  output logic        meas_ready
);

  spi_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic        long_q, long_d;
  logic [31:0] sr_q, sr_d;
  logic [23:0] rx_q, rx_d;
  logic [23:0] rd_q, rd_d;
  logic        done_q, done_d;
  logic        csb_q, csb_d;
  logic        sclk_rise, sclk_fall;
  logic        intb_s1_q, intb_s2_q, intb_edge_q, meas_q;
  logic [7:0]  cmd;

  assign cmd = make_cmd(cmd_autoinc, cmd_write, cmd_addr);

  tdc_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk_i  (tdc_clk),
    .rst_ni (tdc_rstb),
    .en_i   (state_q == ST_SHIFT),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall),
    .sclk_o (tdc_sclk)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    long_d  = long_q;
    sr_d    = sr_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CS_SETUP;
          cnt_d   = '0;
          bit_d   = '0;
          long_d  = cmd_long;
          // The frame is left-justified so the MSB always drives tdc_din.
          if (cmd_long) sr_d = {cmd, cmd_write ? wr_data : 24'h0};
          else          sr_d = {cmd, cmd_write ? wr_data[7:0] : 8'h0, 16'h0};
        end
      end
      ST_CS_SETUP: begin
        if (cnt_q == 8'(CS_SETUP - 1)) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 8'd1;
      end
      ST_SHIFT: begin
        if (sclk_rise) rx_d = {rx_q[22:0], tdc_dout};
        if (sclk_fall) begin
          sr_d  = {sr_q[30:0], 1'b0};
          bit_d = bit_q + 5'd1;
          if (bit_q == (long_q ? 5'd31 : 5'd15)) begin
            state_d = ST_CS_HOLD;
            cnt_d   = '0;
          end
        end
      end
      ST_CS_HOLD: begin
        if (cnt_q == 8'(CS_HOLD - 1)) begin
          state_d = ST_CS_GAP;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 8'd1;
      end
      ST_CS_GAP: begin
        if (cnt_q == 8'(CS_GAP - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          rd_d    = long_q ? rx_q : {16'h0, rx_q[7:0]};
        end else cnt_d = cnt_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    csb_d = !((state_d == ST_CS_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_CS_HOLD));
  end

  always_ff @(posedge tdc_clk or negedge tdc_rstb) begin
    if (!tdc_rstb) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      long_q  <= 1'b0;
      sr_q    <= '0;
      rx_q    <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
      csb_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      long_q  <= long_d;
      sr_q    <= sr_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      csb_q   <= csb_d;
    end
  end

  // Interrupt path: two sync flops, a delayed copy, and a registered edge pulse.
  always_ff @(posedge tdc_clk or negedge tdc_rstb) begin
    if (!tdc_rstb) begin
      intb_s1_q   <= 1'b1;
      intb_s2_q   <= 1'b1;
      intb_edge_q <= 1'b1;
      meas_q      <= 1'b0;
    end else begin
      intb_s1_q   <= tdc_intb;
      intb_s2_q   <= intb_s1_q;
      intb_edge_q <= intb_s2_q;
      meas_q      <= intb_edge_q && !intb_s2_q;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign rd_data    = rd_q;
  assign tdc_csb    = csb_q;
  assign tdc_din    = sr_q[31];
  assign meas_ready = meas_q;

endmodule

// File: doc/tdc_spi_master.md
Name: tdc_spi_master

Overview:
SPI master (mode 0) that runs register transactions with the TDC7200. It generates tdc_sclk and tdc_csb, serialises a command byte plus 1 or 3 data bytes MSB-first on tdc_din, and captures tdc_dout into a parallel read word. It also synchronises tdc_intb and emits a single-cycle measurement-ready pulse. It sits between the acquisition control FSM and the TDC7200 pins.

Parameters:
CLK_DIV, 2, tdc_clk cycles per sclk half-period (>=1)
CS_SETUP, 2, cycles with csb low before the first sclk rise
CS_HOLD, 2, cycles with csb low after the last sclk fall
CS_GAP, 2, minimum csb-high cycles before busy drops

Ports:
tdc_clk  in  1  system clock
tdc_rstb  in  1  asynchronous active-low reset
start  in  1  transaction request; sampled only when busy=0
cmd_addr  in  6  TDC7200 register address
cmd_write  in  1  1=write, 0=read
cmd_autoinc  in  1  auto-increment bit of the command byte
cmd_long  in  1  0=1 data byte, 1=3 data bytes
wr_data  in  24  write payload, right-justified
busy  out  1  transaction in progress
done  out  1  one-cycle pulse at end of transaction
rd_data  out  24  captured read payload, right-justified
tdc_sclk  out  1  SPI clock, idle low
tdc_csb  out  1  chip select, active low, idle high
tdc_din  out  1  serial data to TDC7200
tdc_dout  in  1  serial data from TDC7200
tdc_intb  in  1  asynchronous interrupt from TDC7200, active low
meas_ready  out  1  one-cycle pulse on a synchronised falling edge of tdc_intb

Behaviour:
- Reset values: busy=0, done=0, rd_data=0, tdc_sclk=0, tdc_csb=1, tdc_din=0, meas_ready=0, FSM=IDLE. Sync flops reset to 1. Reset is effective immediately, including mid-transfer.
- Command byte = {cmd_autoinc, cmd_write, cmd_addr}. nbits = 16 (cmd_long=0) or 32 (cmd_long=1).
- On start in IDLE: latch all cmd_* and wr_data. Load the shift register with {cmd, wr_data[7:0]} or {cmd, wr_data[23:0]}. For reads, data bits are 0. busy=1 and csb=0 on the next edge.
- FSM states: IDLE -> CS_SETUP (CS_SETUP cycles) -> SHIFT -> CS_HOLD (CS_HOLD cycles, sclk low, csb low) -> CS_GAP (CS_GAP cycles, csb high) -> IDLE.
- SHIFT: tdc_din = shift-register MSB. After CLK_DIV cycles, sclk rises and tdc_dout is sampled. After another CLK_DIV cycles, sclk falls, the register shifts left and the bit counter increments. Leave SHIFT after the nbits-th fall.
- busy stays high for exactly CS_SETUP + 2*CLK_DIV*nbits + CS_HOLD + CS_GAP cycles (default 70 short, 134 long).
- done pulses in the first cycle busy=0. rd_data updates in the same cycle: the last 8 or 24 sampled bits, with the upper bits zeroed for a short read. For writes, rd_data holds the bits sampled during the data phase.
- start while busy is ignored. No queueing.
- tdc_din is stable across every sclk rising edge and changes only on a falling edge or in CS_SETUP.
- intb path: 2-flop synchroniser plus an edge register. meas_ready pulses exactly one cycle on the 3rd tdc_clk edge after tdc_intb falls. A held-low intb gives no further pulses. Works independently of, and concurrently with, SPI activity.

Decomposition:
- Package tdc7200_pkg holds:
  - register addresses: CONFIG1=0x00, CONFIG2=0x01, INT_STATUS=0x02, TIME1=0x10, CLOCK_COUNT1=0x11, CALIBRATION1=0x1B, CALIBRATION2=0x1C
  - command bit positions: AUTOINC=7, RW=6
  - FSM state encoding
- One sub-module, tdc_sclk_div: half-period counter that issues rise/fall strobes. It is enabled only in SHIFT and cleared otherwise.

Test Plan:
- Short write, defaults: addr=0x00, write, data=0x03 -> tdc_din bits 0x40 then 0x03 over 16 sclk rises; csb low for 68 cycles; busy 70 cycles; done once.
- Long read of TIME1 (0x10, autoinc=0), model returns 0xABCDEF -> command 0x10 on din, din=0 during data, rd_data=0xABCDEF; busy 134 cycles.
- Short read of INT_STATUS (0x02), model returns 0x19 -> rd_data=0x000019; a second start pulsed mid-transfer is ignored (one done only).
- Reset asserted during bit 10 of a long transfer -> csb=1, sclk=0, busy=0 immediately with no done; the next write of 0x01 to CONFIG2 completes normally.
- tdc_intb driven low during an active transfer and held -> meas_ready pulses once, 3 cycles later; SPI timing undisturbed.
- CLK_DIV=1 short write -> sclk period 2 cycles; busy = 2+32+2+2 = 38 cycles; bit sequence correct.
